// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_ctrl
//  Purpose  : Fetch sequencer for the PC datapath. Drives the PC-register
//             load enable and the next-PC select (PC+4 / PC+ImmOp), runs a
//             req/ack handshake to instruction memory at address PC, holds PC
//             while stalled, defers taken branches to the next fetch
//             completion and flags memory timeouts.
//  Ports    : clk         in   rising-edge clock
//             rst         in   asynchronous active-low reset
//             PC          in   current PC from PC register
//             stall       in   1 = do not start a new fetch
//             branch_req  in   taken-branch pulse from decode
//             imem_ack    in   instruction memory data valid
//             imem_rdata  in   instruction memory read data
//             imem_req    out  fetch request
//             imem_addr   out  fetch address (always PC)
//             pc_en       out  PC register load enable
//             PCsrc       out  0 = PC+4, 1 = PC+ImmOp
//             instr       out  last fetched instruction
//             instr_valid out  one-cycle pulse, instr updated
//             fetch_err   out  sticky timeout flag
//  Revision : 1.0  initial release
// ============================================================================
module pc_fetch_ctrl #(
  parameter int WIDTH    = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  PC,
  input  logic              stall,
  input  logic              branch_req,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              imem_req,
  output logic [WIDTH-1:0]  imem_addr,
  output logic              pc_en,
  output logic              PCsrc,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              fetch_err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] C_LAST_WAIT = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               branch_pend_q, branch_pend_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               fetch_err_q, fetch_err_d;
  logic [DATA_W-1:0]  instr_q, instr_d;
  logic               instr_valid_q, instr_valid_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_BOOT;
      branch_pend_q <= 1'b0;
      wait_cnt_q    <= '0;
      fetch_err_q   <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      branch_pend_q <= branch_pend_d;
      wait_cnt_q    <= wait_cnt_d;
      fetch_err_q   <= fetch_err_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    branch_pend_d = branch_pend_q;
    wait_cnt_d    = wait_cnt_q;
    fetch_err_d   = fetch_err_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    imem_req      = 1'b0;
    imem_addr     = PC;
    pc_en         = 1'b0;
    PCsrc         = 1'b0;

    case (state_q)
      S_BOOT: begin
        state_d = S_ISSUE;
      end

      S_ISSUE: begin
        if (branch_req) branch_pend_d = 1'b1;
        if (!stall) begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
        end
      end

      S_WAIT: begin
        // stall is deliberately not consulted: an issued fetch always completes
        imem_req = 1'b1;
        if (imem_ack) begin
          pc_en         = 1'b1;
          // a branch arriving together with the ack is consumed directly
          PCsrc         = branch_pend_q | branch_req;
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          branch_pend_d = 1'b0;
          state_d       = S_ISSUE;
        end else begin
          if (branch_req) branch_pend_d = 1'b1;
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          if (wait_cnt_q == C_LAST_WAIT) begin
            state_d     = S_ERROR;
            fetch_err_d = 1'b1;
          end
        end
      end

      S_ERROR: begin
        fetch_err_d = 1'b1;
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign fetch_err   = fetch_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_fetch_ctrl
//  Purpose  : Directed self-checking bench for pc_fetch_ctrl (MAX_WAIT = 4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC;
  logic        stall;
  logic        branch_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        pc_en;
  logic        PCsrc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_err;

  int n_err   = 0;
  int n_check = 0;

  pc_fetch_ctrl #(.WIDTH(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .PC         (PC),
    .stall      (stall),
    .branch_req (branch_req),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .pc_en      (pc_en),
    .PCsrc      (PCsrc),
    .instr      (instr),
    .instr_valid(instr_valid),
    .fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_check++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // check the combinational handshake outputs after inputs have settled
  task automatic chk_out(input string tag, input logic req, input logic en, input logic src);
    #1;
    chk({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, req});
    chk({tag, ".pc_en"},    {31'd0, pc_en},    {31'd0, en});
    chk({tag, ".PCsrc"},    {31'd0, PCsrc},    {31'd0, src});
  endtask

  initial begin
    rst = 1'b0; PC = 32'h0; stall = 1'b0; branch_req = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    tick(); tick();
    // reset state
    chk_out("rst", 1'b0, 1'b0, 1'b0);
    chk("rst.instr", instr, 32'h0);
    chk("rst.instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst.fetch_err", {31'd0, fetch_err}, 32'd0);
    chk("rst.imem_addr", imem_addr, 32'h0);

    // ---- test 1: boot, first fetch with immediate ack ----
    rst = 1'b1;                                   // c1 BOOT
    chk_out("t1.c1", 1'b0, 1'b0, 1'b0);
    tick();                                       // c2 ISSUE
    chk_out("t1.c2", 1'b0, 1'b0, 1'b0);
    tick();                                       // c3 WAIT, ack
    imem_ack = 1'b1; imem_rdata = 32'h00500093;
    chk_out("t1.c3", 1'b1, 1'b1, 1'b0);
    chk("t1.c3.addr", imem_addr, 32'h0);
    tick();                                       // c4 ISSUE, branch pulse
    imem_ack = 1'b0; imem_rdata = 32'hDEADBEEF; PC = 32'h4; branch_req = 1'b1;
    chk_out("t1.c4", 1'b0, 1'b0, 1'b0);
    chk("t1.c4.instr", instr, 32'h00500093);
    chk("t1.c4.valid", {31'd0, instr_valid}, 32'd1);

    // ---- test 2: pending branch applied on ack 2 cycles into WAIT ----
    tick();                                       // WAIT cycle 1
    branch_req = 1'b0;
    chk_out("t2.w1", 1'b1, 1'b0, 1'b0);
    chk("t2.w1.valid", {31'd0, instr_valid}, 32'd0);
    chk("t2.w1.instr", instr, 32'h00500093);
    chk("t2.w1.addr", imem_addr, 32'h4);
    tick();                                       // WAIT cycle 2, ack
    imem_ack = 1'b1; imem_rdata = 32'h12345678;
    chk_out("t2.w2", 1'b1, 1'b1, 1'b1);
    tick();                                       // ISSUE
    imem_ack = 1'b0; PC = 32'h100;
    chk_out("t2.iss", 1'b0, 1'b0, 1'b0);
    chk("t2.iss.instr", instr, 32'h12345678);
    chk("t2.iss.valid", {31'd0, instr_valid}, 32'd1);
    tick();                                       // WAIT, ack, no branch
    imem_ack = 1'b1; imem_rdata = 32'hCAFEF00D;
    chk_out("t2.next", 1'b1, 1'b1, 1'b0);
    chk("t2.next.addr", imem_addr, 32'h100);

    // ---- test 3: stall held for 5 cycles in ISSUE ----
    tick();
    imem_ack = 1'b0; PC = 32'h104; stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk_out($sformatf("t3.stall%0d", i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    stall = 1'b0;                                 // still ISSUE this cycle
    chk_out("t3.release", 1'b0, 1'b0, 1'b0);
    tick();                                       // WAIT cycle 1

    // ---- test 4: timeout after 4 WAIT cycles without ack ----
    for (int i = 1; i <= 4; i++) begin
      chk_out($sformatf("t4.w%0d", i), 1'b1, 1'b0, 1'b0);
      chk($sformatf("t4.w%0d.err", i), {31'd0, fetch_err}, 32'd0);
      tick();
    end
    chk_out("t4.err", 1'b0, 1'b0, 1'b0);
    chk("t4.err.flag", {31'd0, fetch_err}, 32'd1);
    imem_ack = 1'b1; branch_req = 1'b1; imem_rdata = 32'h0BAD0BAD;
    for (int i = 0; i < 3; i++) begin
      chk_out($sformatf("t4.ign%0d", i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    chk("t4.sticky", {31'd0, fetch_err}, 32'd1);
    chk("t4.noinstr", instr, 32'hCAFEF00D);
    chk("t4.novalid", {31'd0, instr_valid}, 32'd0);

    // ---- test 5: ack in the last allowed WAIT cycle wins ----
    #2 rst = 1'b0;
    chk_out("t5.rst", 1'b0, 1'b0, 1'b0);
    chk("t5.rst.err", {31'd0, fetch_err}, 32'd0);
    chk("t5.rst.instr", instr, 32'h0);
    imem_ack = 1'b0; branch_req = 1'b0; PC = 32'h200;
    tick();
    rst = 1'b1;                                   // BOOT
    tick();                                       // ISSUE
    tick();                                       // WAIT cycle 1
    for (int i = 1; i <= 3; i++) begin
      chk_out($sformatf("t5.w%0d", i), 1'b1, 1'b0, 1'b0);
      tick();
    end
    imem_ack = 1'b1; imem_rdata = 32'h00A00113;   // WAIT cycle 4
    chk_out("t5.w4", 1'b1, 1'b1, 1'b0);
    tick();                                       // ISSUE
    imem_ack = 1'b0;
    chk("t5.err", {31'd0, fetch_err}, 32'd0);
    chk("t5.instr", instr, 32'h00A00113);
    chk("t5.valid", {31'd0, instr_valid}, 32'd1);

    // ---- test 6: reset mid-WAIT drops the pending branch ----
    branch_req = 1'b1;                            // ISSUE: branch pending
    tick();                                       // WAIT cycle 1
    branch_req = 1'b0;
    chk_out("t6.w1", 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b0;
    chk_out("t6.rst", 1'b0, 1'b0, 1'b0);
    chk("t6.rst.valid", {31'd0, instr_valid}, 32'd0);
    chk("t6.rst.instr", instr, 32'h0);
    tick();
    rst = 1'b1;                                   // BOOT
    tick();                                       // ISSUE
    tick();                                       // WAIT, ack
    imem_ack = 1'b1; imem_rdata = 32'h00000013;
    chk_out("t6.ack", 1'b1, 1'b1, 1'b0);
    tick();
    imem_ack = 1'b0;
    chk("t6.instr", instr, 32'h00000013);

    $display("Result: errors=%0d of %0d checks", n_err, n_check);
    $finish;
  end

  // hard time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, errors=%0d", n_err + 1);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
